// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/decode front end: word width, NOP encoding
// and the default instruction memory depth.
package fetch_pkg;

  localparam int WORD_W             = 32;
  localparam int IMEM_DEPTH_DEFAULT = 128;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_instr_mem.sv
// Instruction storage: one combinational read port, one synchronous write port.
// Addresses are word addresses; only the low log2(DEPTH) bits select a word.
module instr_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic  clk,
  input  logic  we,
  input  word_t waddr,
  input  word_t wdata,
  input  word_t raddr,
  output word_t rdata
);

  localparam int AW = $clog2(DEPTH);

  word_t mem [DEPTH];

  // Upper address bits wrap the memory and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{waddr[WORD_W-1:AW], raddr[WORD_W-1:AW]};

  // No reset on the array so a program preloaded during reset survives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem[raddr[AW-1:0]];

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC register, instruction memory and the IF/ID
// pipeline register, with stall hold and taken-branch redirect.
module fetch
  import fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_mem_pc_src,
  input  logic [31:0] ex_mem_npc,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic [31:0] pc
);

  word_t imem_rdata;
  word_t pc_plus1;

  assign pc_plus1 = pc + 32'd1;

  instr_mem #(
    .DEPTH (IMEM_DEPTH)
  ) u_instr_mem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc),
    .rdata (imem_rdata)
  );

  // Redirect outranks stall: a taken branch must flush even a held stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= PC_RESET;
      if_id_instr <= NOP;
      if_id_npc   <= 32'h0;
    end else if (ex_mem_pc_src) begin
      pc          <= ex_mem_npc;
      if_id_instr <= NOP;
      if_id_npc   <= 32'h0;
    end else if (!stall) begin
      pc          <= pc_plus1;
      if_id_instr <= imem_rdata;
      if_id_npc   <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: stimulus queues the expected post-edge state,
// a monitor pops and compares after every rising edge.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ex_mem_pc_src;
  logic [31:0] ex_mem_npc;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic [31:0] pc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  fetch #(
    .IMEM_DEPTH (128),
    .PC_RESET   (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .ex_mem_pc_src (ex_mem_pc_src),
    .ex_mem_npc    (ex_mem_npc),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .if_id_instr   (if_id_instr),
    .if_id_npc     (if_id_npc),
    .pc            (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Monitor: the stage presents a new result on every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      int   f0;
      e  = exp_q.pop_front();
      f0 = failures;
      check({e.name, ".instr"}, if_id_instr, e.instr);
      check({e.name, ".npc"},   if_id_npc,   e.npc);
      check({e.name, ".pc"},    pc,          e.pc);
      if (failures == f0)
        $display("txn %-14s instr=%08h npc=%08h pc=%08h ok", e.name, if_id_instr, if_id_npc, pc);
    end
  end

  // Called at a falling edge: drive one cycle of inputs, queue the expectation,
  // and return at the next falling edge.
  task automatic cyc(input string name, input logic st, input logic src, input logic [31:0] tgt,
                     input logic we, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [31:0] e_instr, input logic [31:0] e_npc, input logic [31:0] e_pc);
    exp_t e;
    stall         = st;
    ex_mem_pc_src = src;
    ex_mem_npc    = tgt;
    imem_we       = we;
    imem_waddr    = wa;
    imem_wdata    = wd;
    e.name = name; e.instr = e_instr; e.npc = e_npc; e.pc = e_pc;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] wa, input logic [31:0] wd);
    imem_we    = 1'b1;
    imem_waddr = wa;
    imem_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    imem_we    = 1'b0;
  endtask

  task automatic check_reset(input string name);
    check({name, ".pc"},    pc,          32'h0);
    check({name, ".instr"}, if_id_instr, 32'h0);
    check({name, ".npc"},   if_id_npc,   32'h0);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; ex_mem_pc_src = 1'b0; ex_mem_npc = 32'h0;
    imem_we = 1'b0; imem_waddr = 32'h0; imem_wdata = 32'h0;
    #1;
    check_reset("reset_init");

    @(negedge clk);
    wr(32'd0, 32'h00a41020);
    wr(32'd1, 32'h10000008);
    wr(32'd2, 32'h8c820002);
    wr(32'd3, 32'hac820002);
    wr(32'd8, 32'h00421020);
    wr(32'd9, 32'h11111111);

    rst = 1'b1;
    cyc("seq0",      0, 0, 0,   0, 0, 0, 32'h00a41020, 32'd1, 32'd1);
    cyc("seq1",      0, 0, 0,   0, 0, 0, 32'h10000008, 32'd2, 32'd2);
    cyc("seq2",      0, 0, 0,   0, 0, 0, 32'h8c820002, 32'd3, 32'd3);
    cyc("seq3",      0, 0, 0,   0, 0, 0, 32'hac820002, 32'd4, 32'd4);
    cyc("redir_to3", 0, 1, 3,   0, 0, 0, 32'h0,        32'd0, 32'd3);
    cyc("redir_to8", 0, 1, 8,   0, 0, 0, 32'h0,        32'd0, 32'd8);
    cyc("after_br",  0, 0, 0,   0, 0, 0, 32'h00421020, 32'd9, 32'd9);
    cyc("after_br2", 0, 0, 0,   0, 0, 0, 32'h11111111, 32'd10, 32'd10);

    cyc("redir_to1", 0, 1, 1,   0, 0, 0, 32'h0,        32'd0, 32'd1);
    cyc("fetch_pc1", 0, 0, 0,   0, 0, 0, 32'h10000008, 32'd2, 32'd2);
    // imem[127] is written during the stall to show writes ignore the hold.
    cyc("stall0",    1, 0, 0,   1, 127, 32'h7f7f7f7f, 32'h10000008, 32'd2, 32'd2);
    cyc("stall1",    1, 0, 0,   0, 0, 0, 32'h10000008, 32'd2, 32'd2);
    cyc("stall_br",  1, 1, 0,   0, 0, 0, 32'h0,        32'd0, 32'd0);
    cyc("post_stall",0, 0, 0,   0, 0, 0, 32'h00a41020, 32'd1, 32'd1);

    cyc("redir_127", 0, 1, 127, 0, 0, 0, 32'h0,        32'd0,   32'd127);
    cyc("wrap0",     0, 0, 0,   0, 0, 0, 32'h7f7f7f7f, 32'd128, 32'd128);
    cyc("wrap1",     0, 0, 0,   0, 0, 0, 32'h00a41020, 32'd129, 32'd129);
    // pc=129 maps to word 1; overwrite it in the same cycle via an aliased address.
    cyc("wr_old",    0, 0, 0,   1, 32'd129, 32'h22222222, 32'h10000008, 32'd130, 32'd130);
    cyc("redir_1b",  0, 1, 1,   0, 0, 0, 32'h0,        32'd0, 32'd1);
    cyc("wr_new",    0, 0, 0,   0, 0, 0, 32'h22222222, 32'd2, 32'd2);

    // Assert reset mid-stall with a redirect pending; outputs clear without an edge.
    cyc("pre_rst",   1, 0, 0,   0, 0, 0, 32'h22222222, 32'd2, 32'd2);
    ex_mem_pc_src = 1'b1;
    ex_mem_npc    = 32'd50;
    rst = 1'b0;
    #1;
    check_reset("reset_async");
    @(negedge clk);
    wr(32'd0, 32'h33333333);
    check_reset("reset_hold");

    rst = 1'b1;
    cyc("rst_fetch0", 0, 0, 0,  0, 0, 0, 32'h33333333, 32'd1, 32'd1);
    cyc("rst_fetch1", 0, 0, 0,  0, 0, 0, 32'h22222222, 32'd2, 32'd2);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 The block SHALL expose the parameter IMEM_DEPTH, default 128, as the instruction memory depth in 32-bit words (power of two).
REQ-002 The block SHALL expose the parameter PC_RESET, default 32'h0, as the PC value after reset.
REQ-003 The block SHALL have port clk  in  1  as its single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  in  1  as an asynchronous, active-low reset.
REQ-005 The block SHALL have port stall  in  1  as the hazard hold request; while high, PC and IF/ID hold.
REQ-006 The block SHALL have port ex_mem_pc_src  in  1  as the taken-branch redirect strobe.
REQ-007 The block SHALL have port ex_mem_npc  in  32  as the branch target word address.
REQ-008 The block SHALL have port imem_we  in  1  as the instruction memory write enable.
REQ-009 The block SHALL have port imem_waddr  in  32  as the instruction memory write word address.
REQ-010 The block SHALL have port imem_wdata  in  32  as the instruction memory write data.
REQ-011 The block SHALL have port if_id_instr  out  32  as the registered instruction presented to decode.
REQ-012 The block SHALL have port if_id_npc  out  32  as the registered next-PC presented to decode.
REQ-013 The block SHALL have port pc  out  32  as the current fetch PC.

Function
REQ-014 The PC and all addresses SHALL be word addresses; sequential next-PC = pc + 1, modulo 2^32.
REQ-015 The memory read index SHALL be pc modulo IMEM_DEPTH, and the write index SHALL be imem_waddr modulo IMEM_DEPTH.
REQ-016 The memory read SHALL be combinational from pc; writes SHALL be synchronous on imem_we; a same-cycle read of the written address SHALL return the old data.
REQ-017 When ex_mem_pc_src=0 and stall=0, each edge SHALL load pc <= pc+1, if_id_instr <= imem[pc] and if_id_npc <= pc+1.
REQ-018 When ex_mem_pc_src=1, the edge SHALL load pc <= ex_mem_npc, if_id_instr <= NOP and if_id_npc <= 32'h0, regardless of stall.
REQ-019 When stall=1 and ex_mem_pc_src=0, the edge SHALL leave pc, if_id_instr and if_id_npc unchanged.
REQ-020 Fetch latency SHALL be one cycle: the word at pc appears on if_id_instr after the next rising edge.
REQ-021 imem_we SHALL be honoured independently of stall, redirect and the pipeline state.

Reset
REQ-022 While rst=0, the block SHALL force pc=PC_RESET, if_id_instr=NOP and if_id_npc=32'h0 asynchronously.
REQ-023 Instruction memory contents SHALL NOT be cleared by reset, and imem_we SHALL remain functional while rst=0 so the program can be preloaded.
REQ-024 On the first edge after rst deasserts, the block SHALL fetch imem[PC_RESET], even when rst is asserted in the middle of a stall or redirect.

Structure
REQ-025 A shared package SHALL hold NOP (32'h00000000), the word width (32) and the default IMEM_DEPTH, imported by fetch and decode alike.
REQ-026 The block SHALL contain one sub-module, instr_mem, providing the storage with one combinational read port and one synchronous write port; PC logic and the IF/ID register SHALL live in fetch.

Verification
REQ-027 Sequential fetch test: preload imem[0..3]=00a41020, 10000008, 8c820002, ac820002, then release rst -> successive edges give (instr, npc) = (00a41020, 1), (10000008, 2), (8c820002, 3), (ac820002, 4).
REQ-028 Redirect test: at pc=3, pulse ex_mem_pc_src=1 with ex_mem_npc=8 and imem[8]=00421020 -> the next edge gives instr=0, npc=0, pc=8; the following edge gives instr=00421020, npc=9.
REQ-029 Stall and priority test: hold stall=1 for 2 cycles at pc=2 -> outputs and pc frozen; then stall=1 with ex_mem_pc_src=1 and target 0 -> pc=0 and a NOP is inserted.
REQ-030 Wrap test: with IMEM_DEPTH=128 and pc=127, sequential fetches read imem[127] then imem[0], with if_id_npc=128 then 129.
REQ-031 Reset and write test: assert rst mid-run -> outputs zero immediately without a clock edge; imem writes during reset persist; write imem[pc] while fetching -> the old word is fetched and the new word is fetched on the next visit.
